// File: rtl/fx_chain_sequencer_pkg.sv
// Shared state type and width helpers for the effect-chain sequencer and its FIFO.
package fx_chain_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_WAIT   = 2'd2
    } fx_state_t;

    // Bits needed to represent every value in 0..max_val.
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/fx_chain_sequencer_sample_fifo.sv
// Synchronous first-word-fall-through sample FIFO; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module sample_fifo
    import fx_chain_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = cnt_w(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full     = (r_count == FULL_CNT);
    assign o_empty    = (r_count == '0);
    assign o_pop_data = r_mem[r_rd_ptr];
    assign w_do_pop   = i_pop && !o_empty;
    assign w_do_push  = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fx_chain_sequencer.sv
// Runs each buffered sample through a chain of external effect stages over a
// shared start/done handshake, with per-sample bypass and stall abandonment.
module fx_chain_sequencer
    import fx_chain_sequencer_pkg::*;
#(
    parameter int unsigned SAMPLE_W   = 12,
    parameter int unsigned NUM_STAGES = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           playback,
    input  logic                           new_sample_ready,
    input  logic signed [SAMPLE_W-1:0]     samples_in,
    input  logic [NUM_STAGES-1:0]          bypass,
    input  logic                           clear_errors,
    output logic [NUM_STAGES-1:0]          stage_start,
    output logic signed [SAMPLE_W-1:0]     stage_sample,
    input  logic [NUM_STAGES*SAMPLE_W-1:0] stage_result,
    input  logic [NUM_STAGES-1:0]          stage_done,
    output logic signed [SAMPLE_W-1:0]     out_sample,
    output logic                           sample_ready,
    output logic                           busy,
    output logic                           overrun,
    output logic                           timeout_err
);

    localparam int unsigned IDX_W = cnt_w(NUM_STAGES);
    localparam int unsigned TMR_W = cnt_w(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES);
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT - 1);

    fx_state_t             r_state;
    logic [IDX_W-1:0]      r_idx;
    logic [TMR_W-1:0]      r_timer;
    logic [SAMPLE_W-1:0]   r_work;
    logic [SAMPLE_W-1:0]   r_out;
    logic [NUM_STAGES-1:0] r_byp_q;
    logic [NUM_STAGES-1:0] r_start;
    logic                  r_ready;
    logic                  r_overrun;
    logic                  r_timeout;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_drop;
    logic                  w_timeout_evt;
    logic [SAMPLE_W-1:0]   w_fifo_data;
    logic                  w_cur_byp;
    logic                  w_cur_done;
    logic [SAMPLE_W-1:0]   w_cur_result;
    logic [NUM_STAGES-1:0] w_sel_onehot;

    assign w_push = playback && new_sample_ready;
    assign w_pop  = (r_state == ST_IDLE) && !w_empty;
    assign w_drop = w_push && w_full && !w_pop;

    sample_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data (samples_in),
        .i_pop       (w_pop),
        .o_pop_data  (w_fifo_data),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    // Decode the active slot; idx==NUM_STAGES matches nothing, so the muxes read as idle.
    always_comb begin
        w_cur_byp    = 1'b0;
        w_cur_done   = 1'b0;
        w_cur_result = '0;
        w_sel_onehot = '0;
        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_cur_byp       = r_byp_q[i];
                w_cur_done      = stage_done[i];
                w_cur_result    = stage_result[i*SAMPLE_W +: SAMPLE_W];
                w_sel_onehot[i] = 1'b1;
            end
        end
    end

    assign w_timeout_evt = (r_state == ST_WAIT) && !w_cur_done && (r_timer == TMR_MAX);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_timer   <= '0;
            r_work    <= '0;
            r_out     <= '0;
            r_byp_q   <= '0;
            r_start   <= '0;
            r_ready   <= 1'b0;
            r_overrun <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            r_start <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_work  <= w_fifo_data;
                        r_byp_q <= bypass;
                        r_idx   <= '0;
                        r_state <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    if (r_idx == LAST_IDX) begin
                        r_out   <= r_work;
                        r_ready <= 1'b1;
                        r_state <= ST_IDLE;
                    end else if (w_cur_byp) begin
                        r_idx <= r_idx + 1'b1;
                    end else begin
                        r_start <= w_sel_onehot;
                        r_timer <= '0;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // An abandoned stage leaves the working sample untouched.
                    if (w_cur_done) begin
                        r_work  <= w_cur_result;
                        r_idx   <= r_idx + 1'b1;
                        r_state <= ST_SELECT;
                    end else if (r_timer == TMR_MAX) begin
                        r_idx   <= r_idx + 1'b1;
                        r_state <= ST_SELECT;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (clear_errors) begin
                r_overrun <= 1'b0;
            end
            if (w_timeout_evt) begin
                r_timeout <= 1'b1;
            end else if (clear_errors) begin
                r_timeout <= 1'b0;
            end
        end
    end

    assign stage_start  = r_start;
    assign stage_sample = r_work;
    assign out_sample   = r_out;
    assign sample_ready = r_ready;
    assign busy         = (r_state != ST_IDLE) || !w_empty;
    assign overrun      = r_overrun;
    assign timeout_err  = r_timeout;

endmodule
